pattern_gen: RTL and testbench

//  Transmit-side counterpart of the pattern detector. On command, serializes a

---
 rtl/pattern_gen.sv | 121 ++++++++++++
 tb/tb_pattern_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Serializes num_pat copies of PATTERN (MSB first) onto a valid/out stream,
// separated by runs of FILL bits, for driving a pattern detector in loopback.
module pattern_gen #(
   parameter int unsigned        PLEN    = 5,
   parameter logic [PLEN-1:0]    PATTERN = 5'b00101,
   parameter logic               FILL    = 1'b1,
   parameter int unsigned        CNT_W   = 8,
   parameter int unsigned        GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_pat,
   input  logic [GAP_W-1:0] gap,
   input  logic             pause,
   output logic             valid,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pat_sent
);

   localparam int unsigned IDX_W = (PLEN > 1) ? $clog2(PLEN) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PLEN - 1);
   localparam logic [IDX_W-1:0] IDX_2ND = IDX_W'(PLEN - 2);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PAT  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   localparam logic [1:0] FIN  = 2'd3;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [GAP_W-1:0] gcnt;
   logic [GAP_W-1:0] gap_lat;
   logic [CNT_W-1:0] num_lat;

   // state/idx/gcnt point at the next bit to emit; the bit itself is registered
   // onto valid/out at the edge that consumes it, so start emits the MSB at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         gcnt     <= '0;
         gap_lat  <= '0;
         num_lat  <= '0;
         valid    <= 1'b0;
         out      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pat_sent <= '0;
      end else begin
         valid <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               out <= 1'b0;
               if (start) begin
                  pat_sent <= '0;
                  if (num_pat != '0) begin
                     num_lat <= num_pat;
                     gap_lat <= gap;
                     busy    <= 1'b1;
                     valid   <= 1'b1;
                     out     <= PATTERN[IDX_TOP];
                     idx     <= IDX_2ND;
                     state   <= PAT;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            PAT: begin
               if (!pause) begin
                  valid <= 1'b1;
                  out   <= PATTERN[idx];
                  if (idx == '0) begin
                     if (pat_sent != '1)
                        pat_sent <= pat_sent + CNT_W'(1);
                     if (pat_sent == num_lat - CNT_W'(1)) begin
                        state <= FIN;
                     end else if (gap_lat != '0) begin
                        gcnt  <= gap_lat;
                        state <= GAP;
                     end else begin
                        idx <= IDX_TOP;
                     end
                  end else begin
                     idx <= idx - IDX_W'(1);
                  end
               end
            end
            GAP: begin
               if (!pause) begin
                  valid <= 1'b1;
                  out   <= FILL;
                  if (gcnt == GAP_W'(1)) begin
                     idx   <= IDX_TOP;
                     state <= PAT;
                  end else begin
                     gcnt <= gcnt - GAP_W'(1);
                  end
               end
            end
            default: begin
               // FIN is entered while the last bit is still on the wire;
               // the done pulse follows in the next cycle.
               if (!done) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  out   <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: expected bit stream queued at each start,
// popped against every valid cycle; latency, done and counters checked per burst.
module tb_pattern_gen;

   localparam logic [4:0] PAT_B = 5'b00101;

   logic       clk = 1'b0;
   logic       rst, start, pause;
   logic [7:0] num_pat;
   logic [3:0] gap;
   logic       valid, out, busy, done;
   logic [7:0] pat_sent;

   pattern_gen #(
      .PLEN    (5),
      .PATTERN (5'b00101),
      .FILL    (1'b1),
      .CNT_W   (8),
      .GAP_W   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .num_pat  (num_pat),
      .gap      (gap),
      .pause    (pause),
      .valid    (valid),
      .out      (out),
      .busy     (busy),
      .done     (done),
      .pat_sent (pat_sent)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0, nvalid = 0, first_v = -1, last_v = -1, ndone = 0, done_cyc = -1;
   bit exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_stream(input int n, input int g);
      for (int c = 0; c < n; c++) begin
         for (int b = 4; b >= 0; b--) exp_q.push_back(PAT_B[b]);
         if (c < n - 1)
            for (int j = 0; j < g; j++) exp_q.push_back(1'b1);
      end
   endtask

   // output monitor: samples on the falling edge
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
         if (valid === 1'b1) begin
            nvalid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (exp_q.size() == 0) chk("extra_bit", valid, 0);
            else chk("bit", out, int'(exp_q.pop_front()));
         end else if (valid !== 1'b0) begin
            chk("valid_x", valid, 0);
         end
         if (done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
      end
   end

   task automatic burst(input int n, input int g, input bit do_pause, input bit poke_start);
      int total, s, paused;
      exp_q.delete();
      push_stream(n, g);
      total  = exp_q.size();
      paused = do_pause ? 3 : 0;
      nvalid = 0; first_v = -1; last_v = -1; ndone = 0; done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1; num_pat = 8'(n); gap = 4'(g);
      @(posedge clk); #1;
      start = 1'b0; num_pat = 8'($urandom); gap = 4'($urandom);
      s = cyc + 1;
      if (do_pause) begin
         @(posedge clk); #1 pause = 1'b1;
         repeat (3) @(posedge clk);
         #1 pause = 1'b0;
      end
      if (poke_start) begin
         @(posedge clk); #1;
         chk("busy_mid", busy, 1);
         start = 1'b1; num_pat = 8'd9; gap = 4'd1;
         @(posedge clk); #1 start = 1'b0;
      end
      for (int i = 0; i < 400 && ndone == 0; i++) begin
         @(posedge clk); #2;
      end
      repeat (3) @(posedge clk);
      #2;
      chk("ndone", ndone, 1);
      chk("nvalid", nvalid, total);
      chk("q_empty", exp_q.size(), 0);
      chk("pat_sent", pat_sent, n);
      chk("busy_idle", busy, 0);
      chk("out_idle", out, 0);
      if (n > 0) begin
         chk("first_lat", first_v, s);
         chk("span", last_v - first_v + 1, total + paused);
         chk("done_lat", done_cyc - last_v, 1);
      end else begin
         chk("done_lat0", done_cyc, s);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nv;
      rst = 1'b1; start = 1'b0; pause = 1'b0; num_pat = '0; gap = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pat_sent", pat_sent, 0);
      rst = 1'b0;

      burst(1, 0, 1'b0, 1'b0);
      burst(3, 2, 1'b0, 1'b1);
      burst(4, 0, 1'b0, 1'b0);
      burst(1, 0, 1'b1, 1'b0);
      burst(3, 1, 1'b1, 1'b0);
      burst(0, 0, 1'b0, 1'b0);
      burst(2, 3, 1'b0, 1'b0);

      // reset during the gap after copy 2 of 5
      exp_q.delete();
      push_stream(5, 3);
      nvalid = 0; ndone = 0;
      @(posedge clk); #1;
      start = 1'b1; num_pat = 8'd5; gap = 4'd3;
      @(posedge clk); #1 start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("mid_pat_sent", pat_sent, 2);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_valid", valid, 0);
      chk("abort_out", out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pat_sent", pat_sent, 0);
      rst = 1'b0;
      exp_q.delete();
      nv = nvalid;
      repeat (5) @(posedge clk);
      #2;
      chk("abort_no_done", ndone, 0);
      chk("abort_no_bits", nvalid, nv);

      burst(1, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
